// File: rtl/decryption_dispatch_pkg.sv
// Shared definitions for the decryption dispatch front/back end:
// end-of-message default, message FSM states and an elaboration-time clog2.
package decryption_pkg;

   localparam logic [7:0] EOM_CHAR_DEFAULT = 8'hFA;

   typedef enum logic {
      IDLE = 1'b0,
      MSG  = 1'b1
   } state_e;

   // Loop stops at bit 30 so the signed shift never wraps negative.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/decryption_dispatch_if.sv
// Master-side input stream: word, valid, message select and the busy back-pressure.
interface decryption_dispatch_if #(
   parameter int MST_DWIDTH = 32,
   parameter int SEL_WIDTH  = 2
);
   logic [SEL_WIDTH-1:0]  select;
   logic [MST_DWIDTH-1:0] data_i;
   logic                  valid_i;
   logic                  busy;

   modport master (
      output select,
      output data_i,
      output valid_i,
      input  busy
   );

   modport slave (
      input  select,
      input  data_i,
      input  valid_i,
      output busy
   );
endinterface

// File: rtl/decryption_dispatch_unpacker.sv
// Word buffer that releases one byte per unstalled edge, MSB slice first,
// and discards the rest of the word once the end-of-message byte goes out.
module word_unpacker
   import decryption_pkg::*;
#(
   parameter int                    MST_DWIDTH = 32,
   parameter int                    SYS_DWIDTH = 8,
   parameter logic [SYS_DWIDTH-1:0] EOM_CHAR   = SYS_DWIDTH'(EOM_CHAR_DEFAULT)
) (
   input  logic                  clk_sys,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [MST_DWIDTH-1:0] word_i,
   input  logic                  stall_i,
   output logic                  busy_o,
   output logic                  emit_o,
   output logic [SYS_DWIDTH-1:0] byte_o,
   output logic                  eom_o
);
   localparam int R     = MST_DWIDTH / SYS_DWIDTH;
   localparam int CNT_W = clog2(R + 1);

   logic [MST_DWIDTH-1:0] buf_q, buf_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   assign busy_o = (cnt_q != CNT_W'(0));
   assign emit_o = busy_o && !stall_i;
   assign byte_o = buf_q[MST_DWIDTH-1 -: SYS_DWIDTH];
   assign eom_o  = emit_o && (byte_o == EOM_CHAR);

   // Next buffer/count: load a fresh word, shift out one byte, or hold on stall.
   always_comb begin
      buf_d = buf_q;
      cnt_d = cnt_q;
      if (load_i) begin
         buf_d = word_i;
         cnt_d = CNT_W'(R);
      end else if (eom_o) begin
         cnt_d = CNT_W'(0);
      end else if (emit_o) begin
         buf_d = buf_q << SYS_DWIDTH;
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         buf_d = buf_q;
         cnt_d = cnt_q;
      end
   end

   // Buffer and count registers.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/decryption_dispatch.sv
// Dispatches unpacked message bytes to NUM_CH decryption engines with the channel
// locked for a whole message, and merges engine results onto one registered stream.
module decryption_dispatch
   import decryption_pkg::*;
#(
   parameter int                    MST_DWIDTH = 32,
   parameter int                    SYS_DWIDTH = 8,
   parameter int                    NUM_CH     = 3,
   parameter int                    SEL_WIDTH  = 2,
   parameter logic [SYS_DWIDTH-1:0] EOM_CHAR   = SYS_DWIDTH'(EOM_CHAR_DEFAULT)
) (
   input  logic                         clk_sys,
   input  logic                         rst,
   decryption_dispatch_if.slave         in_if,
   output logic [NUM_CH*SYS_DWIDTH-1:0] ch_data_o,
   output logic [NUM_CH-1:0]            ch_valid_o,
   input  logic [NUM_CH-1:0]            ch_busy_i,
   input  logic [NUM_CH*SYS_DWIDTH-1:0] eng_data_i,
   input  logic [NUM_CH-1:0]            eng_valid_i,
   output logic [SYS_DWIDTH-1:0]        data_o,
   output logic                         valid_o,
   output logic [SEL_WIDTH-1:0]         active_ch,
   output logic                         sel_error,
   output logic                         collision
);
   if ((MST_DWIDTH % SYS_DWIDTH) != 0) begin : g_bad_width
      $error("decryption_dispatch: MST_DWIDTH must be a multiple of SYS_DWIDTH");
   end
   if (SEL_WIDTH < clog2(NUM_CH)) begin : g_bad_sel
      $error("decryption_dispatch: SEL_WIDTH too narrow for NUM_CH");
   end
   if ((NUM_CH < 2) || (NUM_CH > 16)) begin : g_bad_ch
      $error("decryption_dispatch: NUM_CH must be within 2..16");
   end

   // One extra bit so NUM_CH == 2**SEL_WIDTH still compares correctly.
   localparam logic [SEL_WIDTH:0] NUM_CH_W = (SEL_WIDTH + 1)'(NUM_CH);

   state_e                        state_q;
   logic [SEL_WIDTH-1:0]          active_ch_q;
   logic                          sel_error_q;
   logic [NUM_CH*SYS_DWIDTH-1:0]  ch_data_q;
   logic [NUM_CH-1:0]             ch_valid_q;
   logic [SYS_DWIDTH-1:0]         data_q;
   logic                          valid_q;
   logic                          collision_q;

   logic                  accept_s, sel_ok_s, load_s, stall_s;
   logic                  busy_s, emit_s, eom_s;
   logic [SYS_DWIDTH-1:0] byte_s;
   logic [SYS_DWIDTH-1:0] merge_data_s;
   logic                  collision_s;

   assign accept_s = in_if.valid_i && !busy_s;
   assign sel_ok_s = ({1'b0, in_if.select} < NUM_CH_W);
   assign load_s   = accept_s && ((state_q == MSG) || sel_ok_s);

   // Back-pressure from the engine currently owning the message.
   always_comb begin
      stall_s = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         stall_s = stall_s | ((active_ch_q == SEL_WIDTH'(k)) & ch_busy_i[k]);
      end
   end

   word_unpacker #(
      .MST_DWIDTH (MST_DWIDTH),
      .SYS_DWIDTH (SYS_DWIDTH),
      .EOM_CHAR   (EOM_CHAR)
   ) u_unpacker (
      .clk_sys (clk_sys),
      .rst     (rst),
      .load_i  (load_s),
      .word_i  (in_if.data_i),
      .stall_i (stall_s),
      .busy_o  (busy_s),
      .emit_o  (emit_s),
      .byte_o  (byte_s),
      .eom_o   (eom_s)
   );

   // Message FSM: channel is latched only when a message opens.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         active_ch_q <= '0;
         sel_error_q <= 1'b0;
      end else begin
         sel_error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept_s && sel_ok_s) begin
                  active_ch_q <= in_if.select;
                  state_q     <= MSG;
               end else if (accept_s) begin
                  sel_error_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            MSG: begin
               if (eom_s) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= MSG;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Byte routing; slices of idle engines keep their last byte.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         ch_data_q  <= '0;
         ch_valid_q <= '0;
      end else begin
         ch_valid_q <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            if (emit_s && (active_ch_q == SEL_WIDTH'(k))) begin
               ch_data_q[k*SYS_DWIDTH +: SYS_DWIDTH] <= byte_s;
               ch_valid_q[k]                         <= 1'b1;
            end
         end
      end
   end

   // Lowest-index valid engine wins the merge.
   always_comb begin
      merge_data_s = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         merge_data_s = eng_valid_i[k] ? eng_data_i[k*SYS_DWIDTH +: SYS_DWIDTH] : merge_data_s;
      end
      collision_s = ($countones(eng_valid_i) > 32'sd1);
   end

   // Registered output merge.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         data_q      <= '0;
         valid_q     <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         valid_q     <= |eng_valid_i;
         collision_q <= collision_s;
         if (|eng_valid_i) begin
            data_q <= merge_data_s;
         end else begin
            data_q <= data_q;
         end
      end
   end

   assign in_if.busy = busy_s;
   assign ch_data_o  = ch_data_q;
   assign ch_valid_o = ch_valid_q;
   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign active_ch  = active_ch_q;
   assign sel_error  = sel_error_q;
   assign collision  = collision_q;
endmodule

// File: tb/tb_decryption_dispatch.sv
// Directed plus randomized bench for decryption_dispatch against a message-level model.
module tb_decryption_dispatch;
   localparam int MW   = 32;
   localparam int SW   = 8;
   localparam int NC   = 3;
   localparam int SELW = 2;
   localparam int R    = MW / SW;
   localparam logic [SW-1:0] EOM = 8'hFA;

   logic              clk_sys = 1'b0;
   logic              rst;
   logic [NC*SW-1:0]  ch_data_o;
   logic [NC-1:0]     ch_valid_o;
   logic [NC-1:0]     ch_busy_i;
   logic [NC*SW-1:0]  eng_data_i;
   logic [NC-1:0]     eng_valid_i;
   logic [SW-1:0]     data_o;
   logic              valid_o;
   logic [SELW-1:0]   active_ch;
   logic              sel_error;
   logic              collision;

   int n_err    = 0;
   int n_checks = 0;

   bit            m_open     = 1'b0;
   int            m_ch       = 0;
   int            m_last_ch  = 0;
   logic [SW-1:0] m_data_o   = '0;

   always #5 clk_sys = ~clk_sys;

   decryption_dispatch_if #(.MST_DWIDTH(MW), .SEL_WIDTH(SELW)) in_if ();

   decryption_dispatch #(
      .MST_DWIDTH (MW),
      .SYS_DWIDTH (SW),
      .NUM_CH     (NC),
      .SEL_WIDTH  (SELW),
      .EOM_CHAR   (EOM)
   ) dut (
      .clk_sys     (clk_sys),
      .rst         (rst),
      .in_if       (in_if),
      .ch_data_o   (ch_data_o),
      .ch_valid_o  (ch_valid_o),
      .ch_busy_i   (ch_busy_i),
      .eng_data_i  (eng_data_i),
      .eng_valid_i (eng_valid_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .active_ch   (active_ch),
      .sel_error   (sel_error),
      .collision   (collision)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: a message opens on a valid select in IDLE and closes on the EOM byte.
   task automatic send_word(input logic [SELW-1:0] sel, input logic [MW-1:0] word,
                            input int stall_at, input int stall_len);
      logic [SW-1:0] exp_b[$];
      logic [SW-1:0] b;
      logic [NC-1:0] oh;
      bit            ok;
      int            ch, e, cycles, stalled, want_cycles;
      ok = m_open || (int'(sel) < NC);
      ch = m_open ? m_ch : int'(sel);
      exp_b = {};
      for (int i = 0; i < R; i++) begin
         b = word[MW-1-i*SW -: SW];
         exp_b.push_back(b);
         if (b == EOM) break;
      end
      check("busy_before_accept", 32'(in_if.busy), 32'd0);
      in_if.select  = sel;
      in_if.data_i  = word;
      in_if.valid_i = 1'b1;
      ch_busy_i     = NC'($urandom);
      @(posedge clk_sys); #1;
      in_if.valid_i = 1'b0;
      in_if.data_i  = $urandom;
      if (!ok) begin
         check("sel_error_pulse", 32'(sel_error), 32'd1);
         check("sel_error_no_valid", 32'(ch_valid_o), 32'd0);
         check("sel_error_busy", 32'(in_if.busy), 32'd0);
         check("sel_error_active", 32'(active_ch), 32'(m_last_ch));
         @(posedge clk_sys); #1;
         check("sel_error_clear", 32'(sel_error), 32'd0);
         check("sel_error_no_valid2", 32'(ch_valid_o), 32'd0);
         ch_busy_i = '0;
         return;
      end
      check("active_ch_latch", 32'(active_ch), 32'(ch));
      check("busy_after_accept", 32'(in_if.busy), 32'd1);
      check("no_sel_error", 32'(sel_error), 32'd0);
      oh = '0;
      oh[ch] = 1'b1;
      e = 0; cycles = 0; stalled = 0;
      while ((e < exp_b.size()) && (cycles < 40)) begin
         in_if.select = SELW'($urandom);
         ch_busy_i    = NC'($urandom);
         if ((e == stall_at) && (stalled < stall_len)) begin
            ch_busy_i[ch] = 1'b1;
            stalled++;
         end else begin
            ch_busy_i[ch] = 1'b0;
         end
         @(posedge clk_sys); #1;
         cycles++;
         if (ch_valid_o != '0) begin
            check("ch_valid_onehot", 32'(ch_valid_o), 32'(oh));
            check("ch_byte", 32'(ch_data_o[ch*SW +: SW]), 32'(exp_b[e]));
            e++;
         end
         check("busy_during_msg", 32'(in_if.busy), 32'(e < exp_b.size()));
      end
      want_cycles = exp_b.size() + ((stall_at < exp_b.size()) ? stall_len : 0);
      check("emit_cycles", 32'(cycles), 32'(want_cycles));
      ch_busy_i = '0;
      m_open    = (exp_b[exp_b.size()-1] != EOM);
      m_ch      = ch;
      m_last_ch = ch;
   endtask

   task automatic eng_step(input logic [NC-1:0] v, input logic [NC*SW-1:0] d);
      int            hits;
      logic [SW-1:0] exp_d;
      eng_valid_i = v;
      eng_data_i  = d;
      hits  = 0;
      exp_d = m_data_o;
      for (int k = NC - 1; k >= 0; k--) begin
         if (v[k]) begin
            exp_d = d[k*SW +: SW];
            hits++;
         end
      end
      @(posedge clk_sys); #1;
      m_data_o = exp_d;
      check("merge_valid", 32'(valid_o), 32'(v != '0));
      check("merge_data", 32'(data_o), 32'(exp_d));
      check("merge_collision", 32'(collision), 32'(hits > 1));
   endtask

   initial begin
      logic [MW-1:0] w;
      rst           = 1'b1;
      in_if.select  = '0;
      in_if.data_i  = '0;
      in_if.valid_i = 1'b0;
      ch_busy_i     = '0;
      eng_data_i    = '0;
      eng_valid_i   = '0;
      repeat (2) @(posedge clk_sys);
      #1;
      check("rst_busy", 32'(in_if.busy), 32'd0);
      check("rst_ch_valid", 32'(ch_valid_o), 32'd0);
      check("rst_ch_data", 32'(ch_data_o), 32'd0);
      check("rst_active", 32'(active_ch), 32'd0);
      check("rst_data_o", 32'(data_o), 32'd0);
      check("rst_valid_o", 32'(valid_o), 32'd0);
      check("rst_sel_error", 32'(sel_error), 32'd0);
      check("rst_collision", 32'(collision), 32'd0);
      rst = 1'b0;

      send_word(2'd1, 32'h41424344, 99, 0);
      send_word(2'd0, 32'hFA000000, 99, 0);
      send_word(2'd0, 32'h41FA4243, 99, 0);
      send_word(2'd2, 32'h11223344, 99, 0);
      send_word(2'd0, 32'h55FA6677, 99, 0);
      send_word(2'd0, 32'h01020304, 99, 0);
      send_word(2'd2, 32'h0506FA07, 99, 0);
      send_word(2'd0, 32'h61626364, 1, 3);
      send_word(2'd1, 32'hFAFAFAFA, 99, 0);
      send_word(2'd3, 32'h12345678, 99, 0);

      for (int it = 0; it < 30; it++) begin
         for (int j = 0; j < R; j++) begin
            w[MW-1-j*SW -: SW] = ($urandom_range(0, 3) == 0) ? EOM : SW'($urandom);
         end
         send_word(SELW'($urandom_range(0, 3)), w, $urandom_range(0, 5), $urandom_range(0, 3));
      end

      eng_step(3'b101, {8'hCC, 8'h77, 8'hAA});
      eng_step(3'b000, {8'h01, 8'h02, 8'h03});
      for (int it = 0; it < 20; it++) begin
         eng_step(NC'($urandom), (NC*SW)'($urandom));
      end

      in_if.select  = 2'd1;
      in_if.data_i  = 32'h12345678;
      in_if.valid_i = 1'b1;
      eng_valid_i   = 3'b001;
      eng_data_i    = {8'h00, 8'h00, 8'h5A};
      @(posedge clk_sys); #1;
      in_if.valid_i = 1'b0;
      @(posedge clk_sys); #1;
      check("pre_rst_ch_valid", 32'(ch_valid_o != '0), 32'd1);
      check("pre_rst_valid_o", 32'(valid_o), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_ch_valid", 32'(ch_valid_o), 32'd0);
      check("async_rst_ch_data", 32'(ch_data_o), 32'd0);
      check("async_rst_busy", 32'(in_if.busy), 32'd0);
      check("async_rst_active", 32'(active_ch), 32'd0);
      check("async_rst_data_o", 32'(data_o), 32'd0);
      check("async_rst_valid_o", 32'(valid_o), 32'd0);
      eng_valid_i = '0;
      @(posedge clk_sys); #1;
      rst       = 1'b0;
      m_open    = 1'b0;
      m_last_ch = 0;
      m_data_o  = '0;
      send_word(2'd2, 32'hA1A2FAA3, 99, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
